// File: rtl/fp_sign_align_pipe.sv
// Sign / effective-operation stage of the FP add/sub datapath.
// Resolves eop, result sign, operand swap and exponent difference, then carries them through a LATENCY-deep valid/ready pipeline.
module fp_sign_align_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [1:0]             rm,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   eop,
  output logic                   sign,
  output logic                   swap,
  output logic [EXP_W-1:0]       exp_diff,
  output logic                   zero_res
);

  localparam int W = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic             eop;
    logic             sign;
    logic             swap;
    logic [EXP_W-1:0] exp_diff;
    logic             zero_res;
  } pl_t;

  logic                   a_s, b_s, sbe, a_gt, b_gt, in_fire;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [EXP_W-1:0]       exp_a, exp_b;
  pl_t                    in_pl;

  assign a_s   = a[W-1];
  assign b_s   = b[W-1];
  assign mag_a = a[W-2:0];
  assign mag_b = b[W-2:0];
  assign exp_a = a[W-2 -: EXP_W];
  assign exp_b = b[W-2 -: EXP_W];
  assign a_gt  = mag_a > mag_b;
  assign b_gt  = mag_b > mag_a;

  always_comb begin
    in_pl          = '0;
    sbe            = b_s ^ op;
    in_pl.eop      = a_s ^ sbe;
    in_pl.swap     = b_gt;
    in_pl.exp_diff = b_gt ? (exp_b - exp_a) : (exp_a - exp_b);
    in_pl.zero_res = in_pl.eop & ~a_gt & ~b_gt;
    if (!in_pl.eop || a_gt) in_pl.sign = a_s;
    else if (b_gt)          in_pl.sign = sbe;
    else                    in_pl.sign = (rm == 2'b10);  // exact zero: -0 only when rounding down
  end

  logic [LATENCY-1:0] v_q, v_d, rdy, src_v;
  pl_t                pl_q   [LATENCY];
  pl_t                pl_d   [LATENCY];
  pl_t                src_pl [LATENCY];

  // A stage can load when it is empty or anything downstream can drain,
  // so rdy folds from the output end back toward the input.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = LATENCY-1; k >= 0; k--) begin
      r      = r | ~v_q[k];
      rdy[k] = r;
    end
  end

  assign in_ready = rdy[0] & ~flush;
  assign in_fire  = in_valid & in_ready;

  for (genvar k = 0; k < LATENCY; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_v[k]  = in_fire;
      assign src_pl[k] = in_pl;
    end else begin : g_body
      assign src_v[k]  = v_q[k-1];
      assign src_pl[k] = pl_q[k-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < LATENCY; k++) begin
      pl_d[k] = pl_q[k];
      if (rdy[k])            v_d[k]  = src_v[k];
      if (rdy[k] & src_v[k]) pl_d[k] = src_pl[k];
    end
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) pl_q[k] <= '0;
    end else begin
      v_q  <= v_d;
      pl_q <= pl_d;
    end
  end

  assign out_valid = v_q[LATENCY-1];
  assign {eop, sign, swap, exp_diff, zero_res} = pl_q[LATENCY-1];

endmodule
